// File: rtl/ttc_tx_encoder.sv
// TTC link serial encoder: merges the A channel (trigger accept) and the B channel
// (16-bit broadcast frames, MSB first) into one biphase-mark stream at 160 MHz.
module ttc_tx_encoder (
   input  logic        clk160,
   input  logic        rst,
   input  logic        a_channel,
   input  logic [15:0] ttc_data,
   input  logic        ttc_data_valid,
   output logic        ttc_bit_out
);

   typedef enum logic [1:0] {
      PH_A_START = 2'd0,
      PH_A_MID   = 2'd1,
      PH_B_START = 2'd2,
      PH_B_MID   = 2'd3
   } phase_t;

   phase_t      ph;
   logic        a_pend;
   logic        a_bit;
   logic        b_bit;
   logic        active;
   logic [4:0]  count;
   logic [15:0] shreg;
   logic [15:0] buf_data;
   logic        buf_full;
   logic        b_slot;
   logic        last_bit;

   assign b_slot   = (ph == PH_B_START);
   assign last_bit = b_slot && active && (count == 5'd1);

   // Symbol boundaries always toggle; the mid-symbol toggle carries a 1.
   always_ff @(posedge clk160) begin
      if (rst) begin
         ph          <= PH_A_START;
         ttc_bit_out <= 1'b0;
         a_pend      <= 1'b0;
         a_bit       <= 1'b0;
      end else begin
         ph <= phase_t'(ph + 2'd1);
         case (ph)
            PH_A_START: begin
               ttc_bit_out <= ~ttc_bit_out;
               a_bit       <= a_pend | a_channel;
               a_pend      <= 1'b0;
            end
            PH_A_MID: begin
               ttc_bit_out <= ttc_bit_out ^ a_bit;
               a_pend      <= a_pend | a_channel;
            end
            PH_B_START: begin
               ttc_bit_out <= ~ttc_bit_out;
               a_pend      <= a_pend | a_channel;
            end
            default: begin
               ttc_bit_out <= ttc_bit_out ^ b_bit;
               a_pend      <= a_pend | a_channel;
            end
         endcase
      end
   end

   // A strobe landing on the last-bit edge with an empty buffer goes straight into
   // the shift register, so it still follows the current frame without a gap.
   always_ff @(posedge clk160) begin
      if (rst) begin
         b_bit    <= 1'b1;
         active   <= 1'b0;
         count    <= 5'd0;
         shreg    <= 16'h0000;
         buf_data <= 16'h0000;
         buf_full <= 1'b0;
      end else begin
         if (b_slot) begin
            if (active) begin
               b_bit <= shreg[15];
               if (count == 5'd1) begin
                  if (buf_full) begin
                     shreg    <= buf_data;
                     count    <= 5'd16;
                     buf_full <= 1'b0;
                  end else if (ttc_data_valid) begin
                     shreg <= ttc_data;
                     count <= 5'd16;
                  end else begin
                     shreg  <= {shreg[14:0], 1'b0};
                     count  <= 5'd0;
                     active <= 1'b0;
                  end
               end else begin
                  shreg <= {shreg[14:0], 1'b0};
                  count <= count - 5'd1;
               end
            end else begin
               b_bit <= 1'b1;
            end
         end
         if (ttc_data_valid && !last_bit) begin
            if (!active) begin
               shreg  <= ttc_data;
               active <= 1'b1;
               count  <= 5'd16;
            end else if (!buf_full) begin
               buf_data <= ttc_data;
               buf_full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ttc_tx_encoder.sv
// Self-checking bench for ttc_tx_encoder: a slot-level reference model checked every
// cycle, plus literal expectations decoded straight from the serial line.
module tb_ttc_tx_encoder;

   logic        clk160 = 1'b0;
   logic        rst;
   logic        a_channel;
   logic [15:0] ttc_data;
   logic        ttc_data_valid;
   logic        ttc_bit_out;

   int errors = 0;
   int checks = 0;

   // reference model state: frame bits still to send, one-deep buffer, line level
   int          m_ph;
   logic        m_out, m_aseen, m_abit, m_bbit, m_buf_full;
   logic        m_cur[$];
   logic [15:0] m_buf;

   // sampled inputs and line decode of the DUT output
   logic        r_s, a_s, v_s, pre_active, pre_full, last;
   logic [15:0] d_s;
   int          ph_s;
   logic        lvl_a, lvl_b;
   logic        dec_a[$];
   logic        dec_b[$];
   logic        hist[$];

   logic [7:0]  idle_pat = 8'b11010010;

   ttc_tx_encoder dut (
      .clk160         (clk160),
      .rst            (rst),
      .a_channel      (a_channel),
      .ttc_data       (ttc_data),
      .ttc_data_valid (ttc_data_valid),
      .ttc_bit_out    (ttc_bit_out)
   );

   always #5 clk160 = ~clk160;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic a, input logic v, input logic [15:0] d, input logic r);
      @(negedge clk160);
      a_channel      = a;
      ttc_data_valid = v;
      ttc_data       = d;
      rst            = r;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
   endtask

   task automatic loadFrame(input logic [15:0] d);
      for (int i = 15; i >= 0; i--) m_cur.push_back(d[i]);
   endtask

   // Locate the first frame bit (frames below start with 0; idle B is 1) and check 16 bits.
   task automatic checkFrame(input string name, input int s, input logic [15:0] exp);
      for (int i = 0; i < 16; i++) begin
         if (s + i < dec_b.size()) checkOutput(name, dec_b[s + i], exp[15 - i]);
         else checkOutput({name, "_missing"}, 0, 1);
      end
   endtask

   function automatic int firstZero();
      for (int i = 0; i < dec_b.size(); i++) if (dec_b[i] == 1'b0) return i;
      return dec_b.size();
   endfunction

   function automatic int countOnes();
      int n = 0;
      foreach (dec_a[i]) if (dec_a[i]) n++;
      return n;
   endfunction

   // Model and per-cycle comparison
   initial begin
      m_ph = 0; m_out = 1'b0; m_aseen = 1'b0; m_abit = 1'b0; m_bbit = 1'b1;
      m_buf_full = 1'b0; m_buf = 16'h0000; lvl_a = 1'b0; lvl_b = 1'b0;
      forever begin
         @(posedge clk160);
         r_s = rst; a_s = a_channel; v_s = ttc_data_valid; d_s = ttc_data; ph_s = m_ph;
         if (r_s) begin
            m_out = 1'b0; m_ph = 0; m_aseen = 1'b0; m_abit = 1'b0; m_bbit = 1'b1;
            m_cur.delete(); m_buf_full = 1'b0;
         end else begin
            pre_active = (m_cur.size() != 0);
            pre_full   = m_buf_full;
            last       = 1'b0;
            case (m_ph)
               0: begin m_out = ~m_out; m_abit = m_aseen | a_s; m_aseen = 1'b0; end
               1: begin m_out = m_out ^ m_abit; m_aseen = m_aseen | a_s; end
               2: begin
                  m_out = ~m_out; m_aseen = m_aseen | a_s;
                  if (pre_active) begin
                     m_bbit = m_cur.pop_front();
                     if (m_cur.size() == 0) begin
                        last = 1'b1;
                        if (pre_full) begin loadFrame(m_buf); m_buf_full = 1'b0; end
                        else if (v_s) loadFrame(d_s);
                     end
                  end else m_bbit = 1'b1;
               end
               default: begin m_out = m_out ^ m_bbit; m_aseen = m_aseen | a_s; end
            endcase
            if (v_s && !last) begin
               if (!pre_active) loadFrame(d_s);
               else if (!pre_full) begin m_buf = d_s; m_buf_full = 1'b1; end
            end
            m_ph = (m_ph + 1) % 4;
         end
         #1;
         checkOutput("bit_out", {31'd0, ttc_bit_out}, {31'd0, m_out});
         hist.push_back(ttc_bit_out);
         if (!r_s) begin
            case (ph_s)
               0: lvl_a = ttc_bit_out;
               1: dec_a.push_back(ttc_bit_out ^ lvl_a);
               2: lvl_b = ttc_bit_out;
               default: dec_b.push_back(ttc_bit_out ^ lvl_b);
            endcase
         end
      end
   end

   initial begin
      int s;
      rst = 1'b1; a_channel = 1'b0; ttc_data_valid = 1'b0; ttc_data = 16'h0000;

      // idle pattern after reset
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      hist.delete();
      idleCycles(16);
      for (int i = 0; i < 16; i++) checkOutput("idle_pattern", hist[i], idle_pat[7 - (i % 8)]);

      // single A pulse at each phase -> exactly one A=1 slot
      for (int k = 0; k < 4; k++) begin
         idleCycles(k + 1);
         applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
         dec_a.delete();
         idleCycles(20);
         checkOutput("a_single_pulse", countOnes(), 1);
      end

      // single frame from idle
      applyStimulus(1'b0, 1'b1, 16'h2815, 1'b0);
      dec_b.delete();
      idleCycles(80);
      s = firstZero();
      checkOutput("frame_start_slot", (s <= 1), 1);
      if (s > 1) s = 1;
      checkFrame("frame_2815", s, 16'b0010_1000_0001_0101);
      checkOutput("frame_idle_after", dec_b[s + 16], 1);

      // back-to-back frames, third strobe dropped, A pulses alongside
      applyStimulus(1'b0, 1'b1, 16'h2815, 1'b0);
      dec_b.delete();
      dec_a.delete();
      idleCycles(10);
      applyStimulus(1'b1, 1'b1, 16'hA5C3, 1'b0);
      idleCycles(6);
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      idleCycles(5);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      idleCycles(170);
      s = firstZero();
      if (s > 1) s = 1;
      checkFrame("b2b_first", s, 16'h2815);
      checkFrame("b2b_second", s + 16, 16'hA5C3);
      for (int i = 32; i < 40; i++) checkOutput("b2b_dropped_third", dec_b[s + i], 1);
      checkOutput("a_with_frames", countOnes(), 2);

      // reset mid-frame
      applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
      idleCycles(30);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      hist.delete();
      idleCycles(17);
      checkOutput("reset_out_zero", hist[0], 0);
      for (int i = 0; i < 16; i++) checkOutput("reset_idle_pattern", hist[i + 1], idle_pat[7 - (i % 8)]);

      // randomized traffic, checked cycle by cycle against the model
      for (int i = 0; i < 4000; i++) begin
         applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 23) == 0,
                       16'($urandom), $urandom_range(0, 599) == 0);
      end
      idleCycles(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
